// File: rtl/cla_pkg.sv
// Shared constants and sizing helpers for the carry-lookahead adder.
// The lookahead tree is built from identical 4-lane blocks; these helpers
// tell the top level how many blocks sit at each level of that tree.
package cla_pkg;

   localparam int CLA_GROUP = 4;

   // Number of 4-lane groups needed to cover 'width' lanes, i.e. ceil(width/4).
   function automatic int claNumGroups(input int width);
      return (width + CLA_GROUP - 1) / CLA_GROUP;
   endfunction

   // Number of nodes present at a given level of the tree.
   // Level 0 is the individual bit lanes; each level above groups the one below by four.
   function automatic int claLevelCount(input int width, input int level);
      int count;
      count = width;
      for (int i = 0; i < level; i++) begin
         count = claNumGroups(count);
      end
      return count;
   endfunction

   // Number of block levels required until a single block covers the whole word.
   // Widths up to 4 need one level, up to 16 two, up to 64 three, and so on.
   function automatic int claNumLevels(input int width);
      int count;
      int levels;
      count  = claNumGroups(width);
      levels = 1;
      while (count > 1) begin
         count  = claNumGroups(count);
         levels = levels + 1;
      end
      return levels;
   endfunction

endpackage

// File: rtl/cla_block4.sv
// Four-lane carry-lookahead block.
// Takes generate/propagate for four lanes plus a carry into lane 0 and returns
// the carry out of every lane in flat two-level form, together with the group
// generate and propagate. The same block serves bit lanes and group lanes alike.
module cla_block4 (
   input  logic [3:0] g_i,
   input  logic [3:0] p_i,
   input  logic       cin_i,
   output logic [3:0] carry_o,
   output logic       groupG_o,
   output logic       groupP_o
);

   // Flat lookahead equations: every carry is a sum of products of g, p and cin,
   // so no carry waits on the one below it.
   always_comb begin
      carry_o  = 4'b0000;
      groupG_o = 1'b0;
      groupP_o = 1'b0;

      carry_o[0] = g_i[0]
                 | (p_i[0] & cin_i);

      carry_o[1] = g_i[1]
                 | (p_i[1] & g_i[0])
                 | (p_i[1] & p_i[0] & cin_i);

      carry_o[2] = g_i[2]
                 | (p_i[2] & g_i[1])
                 | (p_i[2] & p_i[1] & g_i[0])
                 | (p_i[2] & p_i[1] & p_i[0] & cin_i);

      groupG_o   = g_i[3]
                 | (p_i[3] & g_i[2])
                 | (p_i[3] & p_i[2] & g_i[1])
                 | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);

      groupP_o   = &p_i;

      carry_o[3] = groupG_o | (groupP_o & cin_i);
   end

endmodule

// File: rtl/carry_lookahead_sumador.sv
// N-bit registered adder built on a hierarchical carry-lookahead tree.
// Level 1 blocks see the bit lanes, each higher level sees the group G/P of
// the level below, and carries flow back down from the single top block, whose
// carry-in is CarryIn. Lanes past the end of a level are padded with g=0, p=0
// so they neither generate nor pass a carry. The sum and carry-out are
// registered once, giving one cycle of latency.
module carry_lookahead_sumador
   import cla_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] Operando1,
   input  logic [N-1:0] Operando2,
   input  logic         CarryIn,
   output logic [N-1:0] Resultado,
   output logic         CarryOut
);

   localparam int LEVELS = claNumLevels(N);

   logic [N-1:0] genBit;
   logic [N-1:0] propBit;
   logic [N-1:0] resultado_d;
   logic [N-1:0] resultado_q;
   logic         carryOut_d;
   logic         carryOut_q;

   assign genBit  = Operando1 & Operando2;
   assign propBit = Operando1 ^ Operando2;

   for (genvar l = 1; l <= LEVELS; l++) begin : gLevel
      localparam int NIN  = claLevelCount(N, l - 1);
      localparam int NOUT = claLevelCount(N, l);
      localparam int NPAD = NOUT * CLA_GROUP;

      logic [NPAD-1:0] gIn;
      logic [NPAD-1:0] pIn;
      logic [NPAD-1:0] cIn;
      logic [NPAD-1:0] cLane;
      logic [NOUT-1:0] gOut;
      logic [NOUT-1:0] pOut;
      logic [NOUT-1:0] cNode;
      logic            unusedLevel;

      if (l == 1) begin : gSrcBits
         assign gIn[NIN-1:0] = genBit;
         assign pIn[NIN-1:0] = propBit;
      end else begin : gSrcLower
         assign gIn[NIN-1:0] = gLevel[l-1].gOut;
         assign pIn[NIN-1:0] = gLevel[l-1].pOut;
      end

      if (NPAD > NIN) begin : gPad
         assign gIn[NPAD-1:NIN] = '0;
         assign pIn[NPAD-1:NIN] = '0;
      end

      if (l == LEVELS) begin : gTop
         assign cNode = CarryIn;
      end else begin : gFromAbove
         assign cNode = gLevel[l+1].cIn[NOUT-1:0];
      end

      for (genvar b = 0; b < NOUT; b++) begin : gBlock
         logic [CLA_GROUP-1:0] blkCarry;

         cla_block4 uBlock (
            .g_i      (gIn[b*CLA_GROUP +: CLA_GROUP]),
            .p_i      (pIn[b*CLA_GROUP +: CLA_GROUP]),
            .cin_i    (cNode[b]),
            .carry_o  (blkCarry),
            .groupG_o (gOut[b]),
            .groupP_o (pOut[b])
         );

         assign cLane[b*CLA_GROUP +: CLA_GROUP] = blkCarry;
         assign cIn[b*CLA_GROUP +: CLA_GROUP]   = {blkCarry[CLA_GROUP-2:0], cNode[b]};
      end

      // The top block's G/P, the padded lanes' carries and the lane carry-outs
      // of the upper levels have no consumer; they are folded here on purpose.
      assign unusedLevel = ^{gOut, pOut, cIn, cLane};
   end

   // Sum bits take the lookahead carry into each lane; carry-out is the carry
   // leaving lane N-1 itself, never a padded lane above it.
   always_comb begin
      resultado_d = propBit ^ gLevel[1].cIn[N-1:0];
      carryOut_d  = gLevel[1].cLane[N-1];
   end

   // Single output register, loaded every cycle and cleared as soon as reset rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resultado_q <= '0;
         carryOut_q  <= 1'b0;
      end else begin
         resultado_q <= resultado_d;
         carryOut_q  <= carryOut_d;
      end
   end

   assign Resultado = resultado_q;
   assign CarryOut  = carryOut_q;

endmodule

// File: tb/tb_carry_lookahead_sumador.sv
// Scoreboard bench for carry_lookahead_sumador at widths 1, 4, 6 and 32.
// All four adders run in lockstep; each stimulus item carries the expected
// result for every width it is meant to check.
module tb_carry_lookahead_sumador;

   typedef struct {
      logic [3:0]  mask;
      logic        a1;
      logic        b1;
      logic        c1;
      logic [1:0]  e1;
      logic [3:0]  a4;
      logic [3:0]  b4;
      logic        c4;
      logic [4:0]  e4;
      logic [5:0]  a6;
      logic [5:0]  b6;
      logic        c6;
      logic [6:0]  e6;
      logic [31:0] a32;
      logic [31:0] b32;
      logic        c32;
      logic [32:0] e32;
      string       name;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        a1, b1, c1, r1, co1;
   logic [3:0]  a4, b4, r4;
   logic        c4, co4;
   logic [5:0]  a6, b6, r6;
   logic        c6, co6;
   logic [31:0] a32, b32, r32;
   logic        c32, co32;

   int checks;
   int failures;
   vec_t scoreQ[$];
   vec_t item;

   carry_lookahead_sumador #(.N(1)) dut1 (
      .clk(clk), .rst(rst), .Operando1(a1), .Operando2(b1), .CarryIn(c1),
      .Resultado(r1), .CarryOut(co1));

   carry_lookahead_sumador #(.N(4)) dut4 (
      .clk(clk), .rst(rst), .Operando1(a4), .Operando2(b4), .CarryIn(c4),
      .Resultado(r4), .CarryOut(co4));

   carry_lookahead_sumador #(.N(6)) dut6 (
      .clk(clk), .rst(rst), .Operando1(a6), .Operando2(b6), .CarryIn(c6),
      .Resultado(r6), .CarryOut(co6));

   carry_lookahead_sumador #(.N(32)) dut32 (
      .clk(clk), .rst(rst), .Operando1(a32), .Operando2(b32), .CarryIn(c32),
      .Resultado(r32), .CarryOut(co32));

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one {CarryOut,Resultado} pair and keep the tallies.
   task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         failures = failures + 1;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Every output of every adder must read zero.
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "/N1"},  {31'b0, co1, r1},  33'b0);
      checkOutput({tag, "/N4"},  {28'b0, co4, r4},  33'b0);
      checkOutput({tag, "/N6"},  {26'b0, co6, r6},  33'b0);
      checkOutput({tag, "/N32"}, {co32, r32},       33'b0);
   endtask

   // Drive one item on the falling edge and queue its expectations for the
   // rising edge that captures it.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      a1  = v.a1;  b1  = v.b1;  c1  = v.c1;
      a4  = v.a4;  b4  = v.b4;  c4  = v.c4;
      a6  = v.a6;  b6  = v.b6;  c6  = v.c6;
      a32 = v.a32; b32 = v.b32; c32 = v.c32;
      scoreQ.push_back(v);
   endtask

   function automatic vec_t blankVec(input string name);
      vec_t v;
      v.mask = 4'b0000;
      v.a1 = 1'b0;  v.b1 = 1'b0;  v.c1 = 1'b0;  v.e1 = '0;
      v.a4 = '0;    v.b4 = '0;    v.c4 = 1'b0;  v.e4 = '0;
      v.a6 = '0;    v.b6 = '0;    v.c6 = 1'b0;  v.e6 = '0;
      v.a32 = '0;   v.b32 = '0;   v.c32 = 1'b0; v.e32 = '0;
      v.name = name;
      return v;
   endfunction

   function automatic vec_t mk1(input logic a, input logic b, input logic c, input logic [1:0] e, input string name);
      vec_t v;
      v = blankVec(name);
      v.mask = 4'b0001;
      v.a1 = a; v.b1 = b; v.c1 = c; v.e1 = e;
      return v;
   endfunction

   function automatic vec_t mk4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [4:0] e, input string name);
      vec_t v;
      v = blankVec(name);
      v.mask = 4'b0010;
      v.a4 = a; v.b4 = b; v.c4 = c; v.e4 = e;
      return v;
   endfunction

   function automatic vec_t mk6(input logic [5:0] a, input logic [5:0] b, input logic c, input logic [6:0] e, input string name);
      vec_t v;
      v = blankVec(name);
      v.mask = 4'b0100;
      v.a6 = a; v.b6 = b; v.c6 = c; v.e6 = e;
      return v;
   endfunction

   function automatic vec_t mk32(input logic [31:0] a, input logic [31:0] b, input logic c, input logic [32:0] e, input string name);
      vec_t v;
      v = blankVec(name);
      v.mask = 4'b1000;
      v.a32 = a; v.b32 = b; v.c32 = c; v.e32 = e;
      return v;
   endfunction

   // Monitor: just after each rising edge, pop the item that edge captured
   // and compare every width it selects.
   always @(posedge clk) begin
      #1;
      if (scoreQ.size() > 0) begin
         item = scoreQ.pop_front();
         if (item.mask[0]) checkOutput({item.name, "/N1"},  {31'b0, co1, r1}, {31'b0, item.e1});
         if (item.mask[1]) checkOutput({item.name, "/N4"},  {28'b0, co4, r4}, {28'b0, item.e4});
         if (item.mask[2]) checkOutput({item.name, "/N6"},  {26'b0, co6, r6}, {26'b0, item.e6});
         if (item.mask[3]) checkOutput({item.name, "/N32"}, {co32, r32},      item.e32);
      end
   end

   // Hard stop in case the run never reaches its summary.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed vectors, asynchronous reset mid-stream,
   // more directed vectors, then back-to-back random vectors.
   initial begin
      vec_t v;
      vec_t dirQ[$];

      checks   = 0;
      failures = 0;
      rst = 1'b1;
      a1 = 1'b0;  b1 = 1'b0;  c1 = 1'b0;
      a4 = '0;    b4 = '0;    c4 = 1'b0;
      a6 = '0;    b6 = '0;    c6 = 1'b0;
      a32 = '0;   b32 = '0;   c32 = 1'b0;

      #2;
      checkAllZero("reset_async");
      @(posedge clk);
      @(posedge clk);
      #1;
      checkAllZero("reset_held");
      #1;
      rst = 1'b0;
      #1;
      checkAllZero("reset_released_no_edge");

      dirQ.push_back(mk1(1'b1, 1'b0, 1'b0, 2'b01, "n1_1p0c0"));
      dirQ.push_back(mk1(1'b1, 1'b0, 1'b1, 2'b10, "n1_1p0c1"));
      dirQ.push_back(mk1(1'b1, 1'b1, 1'b0, 2'b10, "n1_1p1c0"));
      dirQ.push_back(mk1(1'b1, 1'b1, 1'b1, 2'b11, "n1_1p1c1"));
      dirQ.push_back(mk32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000, "n32_full_propagate"));
      dirQ.push_back(mk32(32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000, "n32_msb_carry"));
      dirQ.push_back(mk32(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 33'h0_2222_2221, "n32_mixed"));
      dirQ.push_back(mk32(32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000, "n32_half_ripple"));
      dirQ.push_back(mk6(6'h3F, 6'h01, 1'b0, 7'h40, "n6_wrap"));
      dirQ.push_back(mk6(6'h15, 6'h2A, 1'b1, 7'h40, "n6_alt_cin"));
      dirQ.push_back(mk6(6'h2A, 6'h15, 1'b0, 7'h3F, "n6_alt_nocarry"));
      dirQ.push_back(mk4(4'hF, 4'h1, 1'b0, 5'h10, "n4_wrap"));
      dirQ.push_back(mk4(4'h7, 4'h8, 1'b1, 5'h10, "n4_propagate_cin"));
      dirQ.push_back(mk4(4'h5, 4'h3, 1'b0, 5'h08, "n4_plain"));

      v = blankVec("all_nonzero");
      v.mask = 4'b1111;
      v.a1  = 1'b1;         v.b1  = 1'b1;         v.c1  = 1'b1; v.e1  = 2'b11;
      v.a4  = 4'h5;         v.b4  = 4'h3;         v.c4  = 1'b0; v.e4  = 5'h08;
      v.a6  = 6'h15;        v.b6  = 6'h2A;        v.c6  = 1'b1; v.e6  = 7'h40;
      v.a32 = 32'h1234_5678; v.b32 = 32'h0FED_CBA9; v.c32 = 1'b0; v.e32 = 33'h0_2222_2221;
      dirQ.push_back(v);

      foreach (dirQ[i]) applyStimulus(dirQ[i]);

      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkAllZero("midcycle_reset");
      @(posedge clk);
      #1;
      checkAllZero("reset_over_edge");
      #2;
      rst = 1'b0;
      #1;
      checkAllZero("release_before_edge");

      applyStimulus(mk32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF, "n32_after_reset"));
      applyStimulus(mk6(6'h3F, 6'h3F, 1'b1, 7'h7F, "n6_all_ones"));

      for (int i = 0; i < 10000; i++) begin
         v = blankVec("random");
         v.mask = 4'b1111;
         v.a1  = 1'($urandom);  v.b1  = 1'($urandom);  v.c1  = 1'($urandom);
         v.a4  = 4'($urandom);  v.b4  = 4'($urandom);  v.c4  = 1'($urandom);
         v.a6  = 6'($urandom);  v.b6  = 6'($urandom);  v.c6  = 1'($urandom);
         v.a32 = $urandom;      v.b32 = $urandom;      v.c32 = 1'($urandom);
         v.e1  = {1'b0, v.a1}  + {1'b0, v.b1}  + {1'b0, v.c1};
         v.e4  = {1'b0, v.a4}  + {1'b0, v.b4}  + {4'b0, v.c4};
         v.e6  = {1'b0, v.a6}  + {1'b0, v.b6}  + {6'b0, v.c6};
         v.e32 = {1'b0, v.a32} + {1'b0, v.b32} + {32'b0, v.c32};
         applyStimulus(v);
      end

      repeat (3) @(posedge clk);
      #2;
      checkOutput("scoreboard_drain", 33'(scoreQ.size()), 33'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
